// File: rtl/wb_arbiter_pkg.sv
// Shared register-file types, buffer entry layout and default sizing for the
// writeback arbiter and its long-latency result buffer.
package wb_arbiter_pkg;
  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;

  localparam RegBus ZeroWord    = 32'h0;
  localparam logic  WriteEnable = 1'b1;

  localparam int WB_DEPTH_DEF        = 2;
  localparam int WB_STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    RegAddrBus addr;
    RegBus     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Long-latency result buffer: in-order storage with per-entry occupancy and
// kill-by-address, plus a youngest-first view of every slot for forwarding.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wb_entry_t              push_entry_i,
  input  logic                   pop_i,
  input  logic                   kill_i,
  input  RegAddrBus              kill_addr_i,
  output wb_entry_t              head_o,
  output logic                   head_live_o,
  output logic [CW-1:0]          count_o,
  output logic [DEPTH-1:0]       view_live_o,
  output wb_entry_t [DEPTH-1:0]  view_o
);
  wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      occ_q, dead_q;
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_entry_i;
  end

  // Kill only touches entries already stored; a same-edge push stays live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= '0;
      dead_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_i && occ_q[i] && mem_q[i].addr == kill_addr_i) dead_q[i] <= 1'b1;
      if (pop_i) begin
        occ_q[rd_q]  <= 1'b0;
        dead_q[rd_q] <= 1'b0;
        rd_q         <= inc(rd_q);
      end
      if (push_i) begin
        occ_q[wr_q]  <= 1'b1;
        dead_q[wr_q] <= 1'b0;
        wr_q         <= inc(wr_q);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o      = mem_q[rd_q];
  assign head_live_o = occ_q[rd_q] & ~dead_q[rd_q];
  assign count_o     = cnt_q;

  // view_o[0] is the most recently pushed slot, walking back toward the head.
  always_comb begin
    int idx;
    idx         = 0;
    view_o      = '0;
    view_live_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx            = (int'(wr_q) + 2 * DEPTH - 1 - k) % DEPTH;
      view_o[k]      = mem_q[PW'(idx)];
      view_live_o[k] = occ_q[PW'(idx)] & ~dead_q[PW'(idx)];
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipe writeback wins, buffered long-latency
// results drain otherwise. Define WB_FWD_EN to enable the forwarding query.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WB_DEPTH        = WB_DEPTH_DEF,
  parameter int WB_STARVE_LIMIT = WB_STARVE_LIMIT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pipe_we,
  input  RegAddrBus pipe_waddr,
  input  RegBus     pipe_wdata,
  input  logic      lr_valid,
  input  RegAddrBus lr_waddr,
  input  RegBus     lr_wdata,
  output logic      lr_ready,
  output logic      we,
  output RegAddrBus waddr,
  output RegBus     wdata,
  output logic      stall_req,
  input  RegAddrBus qaddr1,
  input  RegAddrBus qaddr2,
  output logic      qhit1,
  output logic      qhit2,
  output RegBus     qdata1,
  output RegBus     qdata2
);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int SW = $clog2(WB_STARVE_LIMIT + 1);

  logic                     pipe_win, push, pop, head_live;
  wb_entry_t                head;
  logic [CW-1:0]            count;
  logic [WB_DEPTH-1:0]      view_live;
  wb_entry_t [WB_DEPTH-1:0] view;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     stall_q;

  assign pipe_win = pipe_we && (pipe_waddr != '0);
  assign pop      = !pipe_win && (count != '0);
  assign lr_ready = rst && (count < CW'(WB_DEPTH));
  assign push     = lr_valid && lr_ready && (lr_waddr != '0);

  wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_entry_i('{addr: lr_waddr, data: lr_wdata}),
    .pop_i       (pop),
    .kill_i      (pipe_win),
    .kill_addr_i (pipe_waddr),
    .head_o      (head),
    .head_live_o (head_live),
    .count_o     (count),
    .view_live_o (view_live),
    .view_o      (view)
  );

  // A killed head is still popped, but leaves the port idle.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = ZeroWord;
    if (rst) begin
      if (pipe_win) begin
        we    = WriteEnable;
        waddr = pipe_waddr;
        wdata = pipe_wdata;
      end else if (pop && head_live) begin
        we    = WriteEnable;
        waddr = head.addr;
        wdata = head.data;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop)
      starve_d = '0;
    else if (pipe_win && count != '0 && starve_q != SW'(WB_STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= (starve_d == SW'(WB_STARVE_LIMIT));
    end
  end

  assign stall_req = stall_q;

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the youngest live match wins.
  always_comb begin
    qhit1  = 1'b0;
    qhit2  = 1'b0;
    qdata1 = ZeroWord;
    qdata2 = ZeroWord;
    for (int k = WB_DEPTH - 1; k >= 0; k--) begin
      if (view_live[k] && qaddr1 != '0 && view[k].addr == qaddr1) begin
        qhit1  = 1'b1;
        qdata1 = view[k].data;
      end
      if (view_live[k] && qaddr2 != '0 && view[k].addr == qaddr2) begin
        qhit2  = 1'b1;
        qdata2 = view[k].data;
      end
    end
  end
`else
  assign qhit1  = 1'b0;
  assign qhit2  = 1'b0;
  assign qdata1 = ZeroWord;
  assign qdata2 = ZeroWord;
  logic fwd_unused;
  assign fwd_unused = ^{view, view_live, qaddr1, qaddr2};
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter against a queue-based model
// of the writeback rules and a shadow register file.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        pipe_we = 1'b0, lr_valid = 1'b0;
  logic [4:0]  pipe_waddr = '0, lr_waddr = '0, qaddr1 = '0, qaddr2 = '0;
  logic [31:0] pipe_wdata = '0, lr_wdata = '0;
  logic        lr_ready, we, stall_req, qhit1, qhit2;
  logic [4:0]  waddr;
  logic [31:0] wdata, qdata1, qdata2;

  int npass = 0, nfail = 0, ntot = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; bit dead; } ment_t;
  ment_t       mq[$];
  int          starve = 0;
  bit          mstall = 1'b0;
  logic [31:0] rf_m[32];
  logic [31:0] rf_d[32];

  always #5 clk = ~clk;

  wb_arbiter #(.WB_DEPTH(DEPTH), .WB_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lr_valid(lr_valid), .lr_waddr(lr_waddr), .lr_wdata(lr_wdata),
    .lr_ready(lr_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req),
    .qaddr1(qaddr1), .qaddr2(qaddr2),
    .qhit1(qhit1), .qhit2(qhit2), .qdata1(qdata1), .qdata2(qdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic drive(input int pw, input int pa, input int pd,
                       input int lv, input int la, input int ld);
    pipe_we    = 1'(pw);
    pipe_waddr = 5'(pa);
    pipe_wdata = 32'(pd);
    lr_valid   = 1'(lv);
    lr_waddr   = 5'(la);
    lr_wdata   = 32'(ld);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // Expected outputs for the current cycle, from the queue model.
  task automatic check_model();
    logic        ew, er, eh1, eh2, pwin, cmp_ad;
    logic [4:0]  ea;
    logic [31:0] ed, ed1, ed2;
    #1;
    pwin = pipe_we && (pipe_waddr != 0);
    ew = 0; ea = 0; ed = 0; cmp_ad = 1;
    eh1 = 0; eh2 = 0; ed1 = 0; ed2 = 0;
    er = rst && (mq.size() < DEPTH);
    if (rst) begin
      if (pwin) begin
        ew = 1; ea = pipe_waddr; ed = pipe_wdata;
      end else if (mq.size() > 0) begin
        if (!mq[0].dead) begin
          ew = 1; ea = mq[0].a; ed = mq[0].d;
        end else cmp_ad = 0;
      end
    end
`ifdef WB_FWD_EN
    foreach (mq[i]) begin
      if (!mq[i].dead && qaddr1 != 0 && mq[i].a == qaddr1) begin eh1 = 1; ed1 = mq[i].d; end
      if (!mq[i].dead && qaddr2 != 0 && mq[i].a == qaddr2) begin eh2 = 1; ed2 = mq[i].d; end
    end
`endif
    chkb("we", we, ew);
    if (cmp_ad) begin
      chk("waddr", 32'(waddr), 32'(ea));
      chk("wdata", wdata, ed);
    end
    chkb("lr_ready", lr_ready, er);
    chkb("stall_req", stall_req, mstall);
    chkb("qhit1", qhit1, eh1);
    chk("qdata1", qdata1, ed1);
    chkb("qhit2", qhit2, eh2);
    chk("qdata2", qdata2, ed2);
  endtask

  // Advance the model across one rising edge.
  task automatic tick();
    bit pwin;
    int sz;
    pwin = pipe_we && (pipe_waddr != 0);
    sz   = mq.size();
    if (we === 1'b1) rf_d[waddr] = wdata;
    if (rst) begin
      if (pwin) begin
        rf_m[pipe_waddr] = pipe_wdata;
        foreach (mq[i]) if (mq[i].a == pipe_waddr) mq[i].dead = 1;
        if (sz > 0 && starve < LIMIT) starve++;
      end else if (sz > 0) begin
        if (!mq[0].dead) rf_m[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
        starve = 0;
      end
      if (lr_valid && sz < DEPTH && lr_waddr != 0) mq.push_back('{lr_waddr, lr_wdata, 1'b0});
      mstall = (starve >= LIMIT);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    check_model();
    tick();
  endtask

  task automatic do_reset();
    rst = 0;
    mq.delete();
    starve = 0;
    mstall = 0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin rf_m[r] = '0; rf_d[r] = '0; end

    // Outputs held quiet while in reset, even with a pipe write presented.
    drive(1, 3, 'h55, 1, 4, 'h66);
    #2;
    check_model();
    chkb("rst_we", we, 1'b0);
    chkb("rst_ready", lr_ready, 1'b0);
    @(negedge clk);
    rst = 1;
    idle();
    check_model();
    chkb("rel_ready", lr_ready, 1'b1);
    tick();

    // Pipe priority, buffered result one cycle later.
    drive(1, 3, 'h11, 1, 5, 'hAA);
    check_model();
    chk("pri_n_addr", 32'(waddr), 32'd3);
    chk("pri_n_data", wdata, 32'h11);
    tick();
    idle();
    check_model();
    chkb("pri_n1_we", we, 1'b1);
    chk("pri_n1_addr", 32'(waddr), 32'd5);
    chk("pri_n1_data", wdata, 32'hAA);
    tick();

    // Same-cycle pipe write and enqueue to one address: buffered value stays.
    drive(1, 4, 'h40, 1, 4, 'h44);
    cyc();
    idle();
    check_model();
    chk("young_live", wdata, 32'h44);
    tick();

    // lr address 0 dropped, pipe address 0 is not a write.
    drive(0, 0, 0, 1, 0, 'h99);
    cyc();
    idle();
    check_model();
    chkb("lr0_we", we, 1'b0);
    tick();
    drive(1, 0, 'h77, 0, 0, 0);
    check_model();
    chkb("pipe0_we", we, 1'b0);
    tick();

    // Kill: stale r7 never reaches the register file.
    drive(0, 0, 0, 1, 7, 'h1);
    cyc();
    drive(1, 7, 'h2, 0, 0, 0);
    cyc();
    idle();
    check_model();
    chkb("kill_we", we, 1'b0);
    tick();
    chk("kill_rf", rf_d[7], 32'h2);

    // Full buffer holds off the third result until one cycle after the pop.
    do_reset();
    drive(1, 1, 'h100, 1, 10, 'hA0); cyc();
    drive(1, 1, 'h101, 1, 11, 'hA1); cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 'h102 + i, 1, 12, 'hA2);
      check_model();
      chkb("full_ready", lr_ready, 1'b0);
      tick();
    end
    drive(0, 0, 0, 1, 12, 'hA2);
    check_model();
    chkb("full_pop_ready", lr_ready, 1'b0);
    chk("full_pop_addr", 32'(waddr), 32'd10);
    tick();
    check_model();
    chkb("full_after_ready", lr_ready, 1'b1);
    tick();
    idle();
    repeat (3) cyc();

    // Starvation: stall after four lost cycles, clears the cycle after a pop.
    do_reset();
    drive(0, 0, 0, 1, 20, 'h20);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 2, i, 0, 0, 0);
      check_model();
      chkb("starve_lo", stall_req, 1'b0);
      tick();
    end
    drive(1, 2, 5, 0, 0, 0);
    check_model();
    chkb("starve_hi", stall_req, 1'b1);
    chk("starve_pipe_addr", 32'(waddr), 32'd2);
    tick();
    idle();
    check_model();
    chkb("starve_pop_stall", stall_req, 1'b1);
    chk("starve_pop_addr", 32'(waddr), 32'd20);
    tick();
    check_model();
    chkb("starve_clr", stall_req, 1'b0);
    tick();

    // Reset mid-operation with two buffered entries.
    do_reset();
    drive(1, 1, 1, 1, 13, 'hD); cyc();
    drive(1, 1, 2, 1, 14, 'hE); cyc();
    drive(1, 1, 3, 0, 0, 0);
    #2;
    rst = 0;
    mq.delete();
    starve = 0;
    mstall = 0;
    check_model();
    chkb("rstmid_we", we, 1'b0);
    chkb("rstmid_ready", lr_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    idle();
    check_model();
    chkb("rstrel_ready", lr_ready, 1'b1);
    chkb("rstrel_we", we, 1'b0);
    tick();
    cyc();

    // Forwarding query with two buffered writes to r9.
    do_reset();
    qaddr1 = 5'd9;
    qaddr2 = 5'd0;
    drive(1, 1, 1, 1, 9, 'h5); cyc();
    drive(1, 1, 2, 1, 9, 'h6); cyc();
    drive(1, 1, 3, 0, 0, 0);
    check_model();
`ifdef WB_FWD_EN
    chkb("fwd_hit1", qhit1, 1'b1);
    chk("fwd_data1", qdata1, 32'h6);
`else
    chkb("fwd_hit1", qhit1, 1'b0);
    chk("fwd_data1", qdata1, 32'h0);
`endif
    chkb("fwd_hit2", qhit2, 1'b0);
    tick();
    idle();
    repeat (3) cyc();

    // Randomized traffic over a small address set to force conflicts.
    do_reset();
    repeat (400) begin
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom));
      qaddr1 = 5'($urandom_range(0, 7));
      qaddr2 = 5'($urandom_range(0, 7));
      cyc();
    end
    idle();
    repeat (DEPTH + 2) cyc();

    for (int r = 1; r < 32; r++) chk($sformatf("rf_r%0d", r), rf_d[r], rf_m[r]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
